// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
// Imported by the arbiter top and its round-robin picker.
package fifo_arb_pkg;

    typedef enum logic {IDLE, BURST} arb_state_t;

    localparam int ARB_NUM_REQ   = 4;
    localparam int ARB_MAX_BURST = 4;

    // Index width that never collapses to zero bits.
    function automatic int arb_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_picker.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NUM_REQ.
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter int  NUM_REQ = ARB_NUM_REQ,
    localparam int IW      = arb_idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [IW-1:0]      winner,
    output logic               any
);

    always_comb begin
        int         idx;
        logic [IW-1:0] w;
        idx    = 0;
        w      = '0;
        winner = '0;
        any    = |req;
        // Scan downward so the candidate closest to ptr is written last.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            w   = idx[IW-1:0];
            if (req[w]) begin
                winner = w;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among
// NUM_REQ valid/ready producers, with full back-pressure and burst cap.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int  NUM_REQ   = ARB_NUM_REQ,
    parameter int  DATA_SIZE = 8,
    parameter int  MAX_BURST = ARB_MAX_BURST,
    localparam int IW        = arb_idx_w(NUM_REQ),
    localparam int CW        = $clog2(MAX_BURST + 1)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_last,
    input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         fifo_full,
    output logic                         fifo_wr_en,
    output logic [DATA_SIZE-1:0]         fifo_data_in,
    output logic [IW-1:0]                grant_id,
    output logic                         grant_active
);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] rr_q, rr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [IW-1:0] winner;
    logic          any;
    logic          in_burst;
    logic          sel_valid;
    logic          sel_last;
    logic          cap;
    logic          xfer;
    logic          done;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req    (req_valid),
        .ptr    (rr_q),
        .winner (winner),
        .any    (any)
    );

    assign in_burst  = (state_q == BURST);
    assign sel_valid = req_valid[grant_q];
    assign sel_last  = req_last[grant_q];
    assign cap       = (cnt_q == CW'(MAX_BURST - 1));
    assign xfer      = in_burst & sel_valid & ~fifo_full;
    // An owner that stops offering while the FIFO has room gives up the port.
    assign done      = (xfer & (sel_last | cap))
                     | (~sel_valid & ~fifo_full);

    assign fifo_wr_en   = xfer;
    assign grant_id     = grant_q;
    assign grant_active = in_burst;

    always_comb begin
        req_ready    = '0;
        fifo_data_in = '0;
        if (in_burst) begin
            req_ready[grant_q] = ~fifo_full;
            fifo_data_in = req_data[int'(grant_q)*DATA_SIZE +: DATA_SIZE];
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (any) begin
                    state_d = BURST;
                    grant_d = winner;
                    cnt_d   = '0;
                    rr_d    = (winner == IW'(NUM_REQ - 1)) ? '0
                            : winner + 1'b1;
                end
            end
            BURST: begin
                if (xfer) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: idle, single burst, round-robin
// rotation with cap, full stall, abandon, and reset mid-burst.
module tb_fifo_wr_arbiter;

    logic        clock;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_data_in;
    logic [1:0]  grant_id;
    logic        grant_active;

    int checks   = 0;
    int failures = 0;

    fifo_wr_arbiter #(
        .NUM_REQ   (4),
        .DATA_SIZE (8),
        .MAX_BURST (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .grant_id     (grant_id),
        .grant_active (grant_active)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wr"}, 32'(fifo_wr_en), 32'd0);
        chk({tag, "_rdy"}, 32'(req_ready), 32'd0);
        chk({tag, "_act"}, 32'(grant_active), 32'd0);
        chk({tag, "_gid"}, 32'(grant_id), 32'd0);
        chk({tag, "_data"}, 32'(fifo_data_in), 32'd0);
    endtask

    logic [1:0] exp_g;
    logic [7:0] exp_d;

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        settle();
        chk_zero("rst");

        // Idle with no requests
        repeat (5) begin
            tick();
            chk("idle_wr", 32'(fifo_wr_en), 32'd0);
            chk("idle_act", 32'(grant_active), 32'd0);
            chk("idle_gid", 32'(grant_id), 32'd0);
        end

        // Single 3-beat burst from requester 1
        req_valid = 4'b0010;
        req_data[15:8] = 8'hA1;
        settle();
        chk("b1_idle_wr", 32'(fifo_wr_en), 32'd0);
        chk("b1_idle_rdy", 32'(req_ready), 32'd0);
        tick();
        chk("b1_act", 32'(grant_active), 32'd1);
        chk("b1_gid", 32'(grant_id), 32'd1);
        chk("b1_wr1", 32'(fifo_wr_en), 32'd1);
        chk("b1_d1", 32'(fifo_data_in), 32'hA1);
        chk("b1_rdy", 32'(req_ready), 32'b0010);
        tick();
        req_data[15:8] = 8'hA2;
        settle();
        chk("b1_wr2", 32'(fifo_wr_en), 32'd1);
        chk("b1_d2", 32'(fifo_data_in), 32'hA2);
        tick();
        req_data[15:8] = 8'hA3;
        req_last = 4'b0010;
        settle();
        chk("b1_wr3", 32'(fifo_wr_en), 32'd1);
        chk("b1_d3", 32'(fifo_data_in), 32'hA3);
        tick();
        req_valid = '0;
        req_last  = '0;
        settle();
        chk("b1_end_act", 32'(grant_active), 32'd0);
        chk("b1_end_wr", 32'(fifo_wr_en), 32'd0);

        // Round-robin rotation, every burst capped at 4 beats
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_valid = 4'b1111;
        req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        settle();
        for (int k = 0; k < 5; k++) begin
            exp_g = 2'(k % 4);
            exp_d = 8'h10 + 8'(exp_g);
            chk("rr_bubble_act", 32'(grant_active), 32'd0);
            chk("rr_bubble_wr", 32'(fifo_wr_en), 32'd0);
            tick();
            for (int b = 0; b < 4; b++) begin
                chk("rr_act", 32'(grant_active), 32'd1);
                chk("rr_gid", 32'(grant_id), 32'(exp_g));
                chk("rr_wr", 32'(fifo_wr_en), 32'd1);
                chk("rr_data", 32'(fifo_data_in), 32'(exp_d));
                chk("rr_rdy", 32'(req_ready), 32'(4'b0001 << exp_g));
                tick();
            end
        end
        req_valid = '0;
        settle();
        chk("rr_end_act", 32'(grant_active), 32'd0);

        // Full stall after beat 2 of a burst from requester 0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_valid = 4'b0001;
        req_data[7:0] = 8'hB1;
        settle();
        tick();
        chk("st_gid", 32'(grant_id), 32'd0);
        chk("st_d1", 32'(fifo_data_in), 32'hB1);
        chk("st_wr1", 32'(fifo_wr_en), 32'd1);
        tick();
        req_data[7:0] = 8'hB2;
        settle();
        chk("st_d2", 32'(fifo_data_in), 32'hB2);
        chk("st_wr2", 32'(fifo_wr_en), 32'd1);
        tick();
        req_data[7:0] = 8'hB3;
        fifo_full = 1'b1;
        settle();
        for (int s = 0; s < 3; s++) begin
            chk("st_hold_wr", 32'(fifo_wr_en), 32'd0);
            chk("st_hold_rdy", 32'(req_ready), 32'd0);
            chk("st_hold_act", 32'(grant_active), 32'd1);
            chk("st_hold_gid", 32'(grant_id), 32'd0);
            tick();
        end
        fifo_full = 1'b0;
        settle();
        chk("st_wr3", 32'(fifo_wr_en), 32'd1);
        chk("st_d3", 32'(fifo_data_in), 32'hB3);
        tick();
        req_data[7:0] = 8'hB4;
        settle();
        chk("st_wr4", 32'(fifo_wr_en), 32'd1);
        chk("st_d4", 32'(fifo_data_in), 32'hB4);
        tick();
        req_valid = '0;
        settle();
        chk("st_cap_act", 32'(grant_active), 32'd0);

        // Requester 2 abandons after one beat; requester 3 is next
        req_valid = 4'b0100;
        req_data[23:16] = 8'hC1;
        req_data[31:24] = 8'hD1;
        settle();
        tick();
        chk("ab_gid", 32'(grant_id), 32'd2);
        chk("ab_d1", 32'(fifo_data_in), 32'hC1);
        chk("ab_wr1", 32'(fifo_wr_en), 32'd1);
        tick();
        req_valid = 4'b1001;
        settle();
        chk("ab_drop_wr", 32'(fifo_wr_en), 32'd0);
        chk("ab_drop_rdy", 32'(req_ready), 32'b0100);
        chk("ab_drop_act", 32'(grant_active), 32'd1);
        tick();
        chk("ab_rel_act", 32'(grant_active), 32'd0);
        chk("ab_rel_wr", 32'(fifo_wr_en), 32'd0);
        tick();
        chk("ab_next_gid", 32'(grant_id), 32'd3);
        chk("ab_next_d", 32'(fifo_data_in), 32'hD1);
        chk("ab_next_wr", 32'(fifo_wr_en), 32'd1);

        // Reset during beat 2 of requester 3's burst
        tick();
        req_data[31:24] = 8'hD2;
        settle();
        chk("rb_d2", 32'(fifo_data_in), 32'hD2);
        reset = 1'b1;
        tick();
        chk_zero("rb");
        reset = 1'b0;
        req_valid = 4'b1111;
        settle();
        tick();
        chk("rb_first_gid", 32'(grant_id), 32'd0);
        chk("rb_first_act", 32'(grant_active), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
